// File: rtl/angle_mod_pkg.sv
// Shared definitions for the angle-modulator DDS.
//   MODE_*     : runtime modulation mode encodings (3 is reserved and runs as CW)
//   LATENCY    : register stages from sample capture to FM_wave
//   dev_width  : width of the deviation scale input (PHASE_WIDTH - INPUT_WIDTH)
package angle_mod_pkg;

    typedef enum logic [1:0] {
        MODE_CW = 2'd0,
        MODE_FM = 2'd1,
        MODE_PM = 2'd2
    } mode_e;

    localparam int LATENCY = 7;

    function automatic int dev_width(input int phase_width, input int input_width);
        return phase_width - input_width;
    endfunction

endpackage

// File: rtl/sine_quarter_rom.sv
// Quarter-wave sine ROM, synchronous read, one cycle latency.
//   clk_in : clock
//   RST_N  : asynchronous reset, active low (clears the read register)
//   addr   : quarter-wave index k, 0 .. 2^LUT_AW-1
//   dout   : round((2^(LUT_DW-1)-1) * sin(pi/2*(k+0.5)/2^LUT_AW)), registered
// The table is built at elaboration by a fixed-point Taylor series, so no
// external memory image is needed and the ROM maps to constant logic.
module sine_quarter_rom
    import angle_mod_pkg::*;
#(
    parameter int LUT_AW = 8,
    parameter int LUT_DW = 14
) (
    input  logic              clk_in,
    input  logic              RST_N,
    input  logic [LUT_AW-1:0] addr,
    output logic [LUT_DW-1:0] dout
);

    localparam int DEPTH = 1 << LUT_AW;

    // Q30 fixed point; Horner form of sin(x) up to x^13, accurate far below
    // half an output LSB over [0, pi/2].
    function automatic logic [DEPTH*LUT_DW-1:0] build_rom();
        longint one, pi_q, amp, x, x2, t, s;
        logic [63:0] v;
        logic [DEPTH*LUT_DW-1:0] img;
        img  = '0;
        one  = 64'sd1 <<< 30;
        pi_q = 64'sd3373259426;
        amp  = (64'sd1 <<< (LUT_DW - 1)) - 64'sd1;
        for (int k = 0; k < DEPTH; k++) begin
            x  = (pi_q * longint'(2 * k + 1)) / longint'(4 * DEPTH);
            x2 = (x * x) >>> 30;
            t  = one - x2 / 156;
            t  = one - ((x2 * t) >>> 30) / 110;
            t  = one - ((x2 * t) >>> 30) / 72;
            t  = one - ((x2 * t) >>> 30) / 42;
            t  = one - ((x2 * t) >>> 30) / 20;
            t  = one - ((x2 * t) >>> 30) / 6;
            s  = (x * t) >>> 30;
            v  = 64'((amp * s + (one >>> 1)) >>> 30);
            img[k*LUT_DW +: LUT_DW] = v[LUT_DW-1:0];
        end
        return img;
    endfunction

    localparam logic [DEPTH*LUT_DW-1:0] ROM_IMG = build_rom();

    always_ff @(posedge clk_in or negedge RST_N) begin
        if (!RST_N) dout <= '0;
        else        dout <= ROM_IMG[addr*LUT_DW +: LUT_DW];
    end

endmodule

// File: rtl/angle_modulator_dds.sv
// DDS angle modulator: CW / FM / PM on a single phase accumulator.
//   clk_in, RST_N : clock, asynchronous active-low reset
//   cfg_load      : latch mode/center_fre/move_fre into shadow registers
//   mode          : 0=CW 1=FM 2=PM 3=CW
//   center_fre    : carrier tuning word
//   move_fre      : unsigned deviation scale
//   phase_off     : static phase offset (live, not shadowed)
//   wave_in       : signed baseband sample, captured when wave_valid=1
//   phase_sync    : clear the accumulator on this edge
//   FM_wave       : signed sine output
//   FM_valid      : set once the pipeline has filled after reset
// Stages: sample -> dev -> mode mux -> acc -> phase -> ROM -> sign.
module angle_modulator_dds
    import angle_mod_pkg::*;
#(
    parameter int INPUT_WIDTH  = 12,
    parameter int PHASE_WIDTH  = 32,
    parameter int OUTPUT_WIDTH = 12,
    parameter int LUT_AW       = 8,
    parameter int LUT_DW       = 14
) (
    input  logic                                clk_in,
    input  logic                                RST_N,
    input  logic                                cfg_load,
    input  logic [1:0]                          mode,
    input  logic [PHASE_WIDTH-1:0]              center_fre,
    input  logic [PHASE_WIDTH-INPUT_WIDTH-1:0]  move_fre,
    input  logic [PHASE_WIDTH-1:0]              phase_off,
    input  logic [INPUT_WIDTH-1:0]              wave_in,
    input  logic                                wave_valid,
    input  logic                                phase_sync,
    output logic [OUTPUT_WIDTH-1:0]             FM_wave,
    output logic                                FM_valid
);

    localparam int PW    = PHASE_WIDTH;
    localparam int IW    = INPUT_WIDTH;
    localparam int OW    = OUTPUT_WIDTH;
    localparam int DEV_W = dev_width(PHASE_WIDTH, INPUT_WIDTH);
    localparam logic [2:0] FILL_DONE = 3'(LATENCY);

    logic [1:0]        mode_s;
    logic [PW-1:0]     center_s;
    logic [DEV_W-1:0]  move_s;
    logic [IW-1:0]     wave_r;
    logic [PW-1:0]     dev, fword, poff, poff_d, acc, phase;
    logic [PW-1:0]     fword_n, poff_n;
    logic [PW:0]       wave_x, move_x, prod;
    logic [1:0]        quad;
    logic [LUT_AW-1:0] quad_idx, rom_addr;
    logic [LUT_DW-1:0] rom_dout;
    logic [OW-1:0]     mag;
    logic              sgn_d;
    logic [2:0]        fill_cnt;

    // Both operands extended to PW+1 bits, so the low bits of the plain
    // product are the signed x unsigned result modulo 2^(PW+1).
    assign wave_x = {{(PW + 1 - IW){wave_r[IW-1]}}, wave_r};
    assign move_x = {{(IW + 1){1'b0}}, move_s};
    assign prod   = wave_x * move_x;

    always_comb begin
        fword_n = center_s;
        poff_n  = '0;
        case (mode_s)
            MODE_FM: fword_n = center_s + dev;
            MODE_PM: poff_n  = dev;
            default: ;
        endcase
    end

    // Quadrant fold: odd quadrants read the table backwards, the upper
    // half-turn negates the magnitude one stage later.
    assign quad     = phase[PW-1 -: 2];
    assign quad_idx = phase[PW-3 -: LUT_AW];
    assign rom_addr = quad[0] ? ~quad_idx : quad_idx;

    sine_quarter_rom #(
        .LUT_AW (LUT_AW),
        .LUT_DW (LUT_DW)
    ) u_rom (
        .clk_in (clk_in),
        .RST_N  (RST_N),
        .addr   (rom_addr),
        .dout   (rom_dout)
    );

    // ROM words are below 2^(LUT_DW-1), so mag's MSB is 0 and -mag fits.
    assign mag = rom_dout[LUT_DW-1 -: OW];

    always_ff @(posedge clk_in or negedge RST_N) begin
        if (!RST_N) begin
            mode_s   <= MODE_CW;
            center_s <= '0;
            move_s   <= '0;
            wave_r   <= '0;
            dev      <= '0;
            fword    <= '0;
            poff     <= '0;
            poff_d   <= '0;
            acc      <= '0;
            phase    <= '0;
            sgn_d    <= 1'b0;
            FM_wave  <= '0;
            fill_cnt <= '0;
        end else begin
            if (cfg_load) begin
                mode_s   <= mode;
                center_s <= center_fre;
                move_s   <= move_fre;
            end
            if (wave_valid) wave_r <= wave_in;
            dev    <= prod[PW-1:0];
            fword  <= fword_n;
            poff   <= poff_n;
            // poff waits one stage so it meets the acc value built from
            // the same sample's fword.
            poff_d <= poff;
            acc    <= phase_sync ? '0 : acc + fword;
            phase  <= acc + poff_d + phase_off;
            sgn_d  <= quad[1];
            FM_wave <= sgn_d ? -mag : mag;
            if (fill_cnt != FILL_DONE) fill_cnt <= fill_cnt + 3'd1;
        end
    end

    assign FM_valid = (fill_cnt == FILL_DONE);

    logic unused_bits;
    assign unused_bits = ^{phase, rom_dout, prod};

endmodule

// File: tb/tb_angle_modulator_dds.sv
module tb_angle_modulator_dds;
    import angle_mod_pkg::*;

    localparam int MAXS = 4096;

    logic        clk_in = 1'b0, RST_N = 1'b0, cfg_load = 1'b0;
    logic        wave_valid = 1'b0, phase_sync = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [31:0] center_fre = '0, phase_off = '0;
    logic [19:0] move_fre = '0;
    logic [11:0] wave_in = '0;
    logic [11:0] FM_wave;
    logic        FM_valid;

    angle_modulator_dds dut (
        .clk_in(clk_in), .RST_N(RST_N), .cfg_load(cfg_load), .mode(mode),
        .center_fre(center_fre), .move_fre(move_fre), .phase_off(phase_off),
        .wave_in(wave_in), .wave_valid(wave_valid), .phase_sync(phase_sync),
        .FM_wave(FM_wave), .FM_valid(FM_valid)
    );

    always #5 clk_in = ~clk_in;

    int n_checks = 0, n_fail = 0;
    int rom_ref [256];

    // Reference model: value of each architectural quantity after edge s
    // (index 0 = reset state), derived from the spec rules per edge.
    logic [11:0] m_wave   [MAXS];
    logic [1:0]  m_mode   [MAXS];
    logic [31:0] m_center [MAXS];
    logic [19:0] m_move   [MAXS];
    logic [31:0] m_dev [MAXS], m_fw [MAXS], m_poff [MAXS], m_acc [MAXS], m_ph [MAXS];
    int s = 0;

    typedef struct {
        logic [1:0]  mode;
        logic [31:0] center;
        logic [19:0] move;
        logic [11:0] wave;
        logic [31:0] poff;
        int          e0, e1, e2, e3;
    } row_t;
    row_t rows [6];

    function automatic int lut(input logic [31:0] ph);
        int idx, m;
        idx = int'(ph[29:22]);
        if (ph[30]) idx = 255 - idx;
        m = rom_ref[idx] >>> 2;
        return ph[31] ? -m : m;
    endfunction

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s (edge %0d): got %0d expected %0d", name, s, got, exp);
        end
    endtask

    task automatic model_reset();
        s = 0;
        m_wave[0] = '0; m_mode[0] = '0; m_center[0] = '0; m_move[0] = '0;
        m_dev[0] = '0; m_fw[0] = '0; m_poff[0] = '0; m_acc[0] = '0; m_ph[0] = '0;
    endtask

    task automatic step();
        int n;
        longint p;
        n = s + 1;
        if (n >= MAXS) begin
            $display("FAIL model_depth: got %0d expected < %0d", n, MAXS);
            $fatal(1, "model history exhausted");
        end
        m_wave[n] = wave_valid ? wave_in : m_wave[s];
        m_mode[n]   = cfg_load ? mode       : m_mode[s];
        m_center[n] = cfg_load ? center_fre : m_center[s];
        m_move[n]   = cfg_load ? move_fre   : m_move[s];
        p = longint'($signed(m_wave[s])) * longint'({1'b0, m_move[s]});
        m_dev[n] = p[31:0];
        m_fw[n] = m_center[s];
        m_poff[n] = '0;
        if (m_mode[s] == 2'd1) m_fw[n] = m_center[s] + m_dev[s];
        if (m_mode[s] == 2'd2) m_poff[n] = m_dev[s];
        m_acc[n] = phase_sync ? 32'd0 : m_acc[s] + m_fw[s];
        m_ph[n] = m_acc[s] + m_poff[(s > 0) ? s - 1 : 0] + phase_off;
        s = n;
        @(posedge clk_in);
        #1;
        check("fm_wave", $signed(FM_wave), (s >= 2) ? lut(m_ph[s-2]) : 0);
        check("fm_valid", int'(FM_valid), (s >= LATENCY) ? 1 : 0);
    endtask

    // Load a config, let it settle, sync, then check 4 outputs starting 3
    // clocks after the sync edge.
    task automatic run_row(input int r);
        mode = rows[r].mode; center_fre = rows[r].center; move_fre = rows[r].move;
        wave_in = rows[r].wave; phase_off = rows[r].poff;
        cfg_load = 1'b1; wave_valid = 1'b1; phase_sync = 1'b0;
        step();
        cfg_load = 1'b0; wave_valid = 1'b0;
        repeat (4) step();
        phase_sync = 1'b1;
        step();
        phase_sync = 1'b0;
        step(); step();
        step(); check($sformatf("row%0d_t0", r), $signed(FM_wave), rows[r].e0);
        step(); check($sformatf("row%0d_t1", r), $signed(FM_wave), rows[r].e1);
        step(); check($sformatf("row%0d_t2", r), $signed(FM_wave), rows[r].e2);
        step(); check($sformatf("row%0d_t3", r), $signed(FM_wave), rows[r].e3);
    endtask

    initial begin
        int prev, cur, last_x, n_int, d;

        for (int k = 0; k < 256; k++)
            rom_ref[k] = $rtoi(8191.0 * $sin(3.141592653589793 / 2.0 * (k + 0.5) / 256.0) + 0.5);

        rows[0] = '{2'd0, 32'h4000_0000, 20'h0,     12'h000, 32'h0,         6, 2047,    -6, -2047};
        rows[1] = '{2'd2, 32'h0,         20'h40000, 12'h400, 32'h0,       789,  789,   789,   789};
        rows[2] = '{2'd2, 32'h0,         20'h40000, 12'hC00, 32'h0,      -777, -777,  -777,  -777};
        rows[3] = '{2'd0, 32'h4000_0000, 20'h0,     12'h000, 32'h2000_0000, 1452, 1443, -1452, -1443};
        rows[4] = '{2'd3, 32'h4000_0000, 20'h40000, 12'h400, 32'h0,         6, 2047,    -6, -2047};
        rows[5] = '{2'd1, 32'h2000_0000, 20'h40000, 12'h400, 32'h0,         6, 1894,  1443,  -789};

        // Reset state
        @(posedge clk_in); #1;
        check("reset_wave", $signed(FM_wave), 0);
        check("reset_valid", int'(FM_valid), 0);
        @(posedge clk_in); #1;
        RST_N = 1'b1;
        model_reset();

        for (int r = 0; r < 6; r++) run_row(r);

        // FM period: fword = 2^28 + 2^19 -> 2^32/fword ~ 15.97 clk
        mode = 2'd1; center_fre = 32'h1000_0000; move_fre = 20'h400;
        wave_in = 12'h200; wave_valid = 1'b1; cfg_load = 1'b1;
        step();
        cfg_load = 1'b0; wave_valid = 1'b0;
        repeat (6) step();
        prev = $signed(FM_wave); last_x = -1; n_int = 0;
        for (int i = 0; i < 80; i++) begin
            step();
            cur = $signed(FM_wave);
            if (prev < 0 && cur > 0) begin
                if (last_x >= 0) begin
                    d = i - last_x;
                    n_int++;
                    n_checks++;
                    if (d < 15 || d > 16) begin
                        n_fail++;
                        $display("FAIL fm_period: got %0d clk expected 15..16", d);
                    end
                end
                last_x = i;
            end
            prev = cur;
        end
        n_checks++;
        if (n_int < 3) begin
            n_fail++;
            $display("FAIL fm_crossings: got %0d intervals expected >= 3", n_int);
        end

        // Zero-order hold: wave_in toggles with wave_valid low
        run_row(1);
        for (int i = 0; i < 12; i++) begin
            wave_valid = 1'b0;
            wave_in = 12'($urandom);
            step();
            check("hold", $signed(FM_wave), 789);
        end

        // Randomized traffic against the model
        for (int i = 0; i < 1200; i++) begin
            mode       = 2'($urandom);
            center_fre = $urandom;
            move_fre   = 20'($urandom);
            cfg_load   = ($urandom_range(0, 15) == 0);
            wave_in    = 12'($urandom);
            wave_valid = $urandom_range(0, 1) == 1;
            phase_sync = ($urandom_range(0, 23) == 0);
            if ($urandom_range(0, 49) == 0) phase_off = $urandom;
            step();
        end
        cfg_load = 1'b0; phase_sync = 1'b0; wave_valid = 1'b0;

        // Asynchronous reset mid-cycle, then a fresh run
        @(posedge clk_in); #3;
        RST_N = 1'b0;
        #1;
        check("async_rst_wave", $signed(FM_wave), 0);
        check("async_rst_valid", int'(FM_valid), 0);
        @(posedge clk_in); #1;
        check("async_rst_hold", $signed(FM_wave), 0);
        mode = '0; center_fre = '0; move_fre = '0; wave_in = '0; phase_off = '0;
        RST_N = 1'b1;
        model_reset();
        run_row(0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
